// File: rtl/fifo_burst_reader.sv
// Burst read engine for the project fifo: pops a programmed number of words and
// streams them out through a 2-entry buffer that hides read latency and back-pressure.
module fifo_burst_reader #(
  parameter int fifo_width = 8,
  parameter int max_burst  = 16,
  localparam int LW        = $clog2(max_burst + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LW-1:0]         burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_read,
  input  logic                  fifo_empty,
  input  logic [fifo_width-1:0] fifo_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [fifo_width-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         issue_rem_q, issue_rem_d;
  logic [LW-1:0]         out_rem_q, out_rem_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [fifo_width-1:0] buf0_q, buf0_d;
  logic [fifo_width-1:0] buf1_q, buf1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic       pop;
  logic [2:0] fill;

  assign pop  = (occ_q != 2'd0) & out_ready;
  assign fill = {1'b0, occ_q} + {2'b00, inflight_q};

  // Issue only if the word will have a buffer slot when it lands next cycle.
  assign fifo_read = (state_q == S_READ) & ~fifo_empty & (issue_rem_q != '0) &
                     (fill < (3'd2 + {2'b00, pop}));

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign out_last  = out_valid & (out_rem_q == LW'(1));
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    issue_rem_d = issue_rem_q;
    out_rem_d   = out_rem_q;
    occ_d       = occ_q;
    inflight_d  = fifo_read;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    // buf0 is always the head; a pop shifts buf1 forward.
    case (occ_q)
      2'd0: begin
        if (inflight_q) begin
          buf0_d = fifo_data_out;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (inflight_q && pop) begin
          buf0_d = fifo_data_out;
        end else if (pop) begin
          occ_d = 2'd0;
        end else if (inflight_q) begin
          buf1_d = fifo_data_out;
          occ_d  = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          buf0_d = buf1_q;
          if (inflight_q) buf1_d = fifo_data_out;
          else            occ_d  = 2'd1;
        end
      end
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue_rem_d = burst_len;
          out_rem_d   = burst_len;
          state_d     = (burst_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (fifo_read) begin
          issue_rem_d = issue_rem_q - LW'(1);
          if (issue_rem_q == LW'(1)) state_d = S_DRAIN;
        end
        if (pop) out_rem_d = out_rem_q - LW'(1);
      end
      S_DRAIN: begin
        if (pop) begin
          out_rem_d = out_rem_q - LW'(1);
          if (out_rem_q == LW'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_READ) | (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      issue_rem_q <= '0;
      out_rem_q   <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_rem_q <= issue_rem_d;
      out_rem_q   <= out_rem_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: fifo model plus stream monitor, directed and random
// bursts checked against the words the fifo was loaded with.
module tb_fifo_burst_reader;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int LW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, fifo_read, fifo_empty, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic [W-1:0]  out_data;

  fifo_burst_reader #(.fifo_width(W), .max_burst(MB)) dut (
    .clk(clk), .rstn(rstn), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_read(fifo_read), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // fifo model: one-cycle read latency
  logic [W-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data_out <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stream monitor
  logic [W:0] got_q [$];
  int         done_cnt = 0;
  int         reads_total = 0;
  int         ost = 0;
  logic       pv = 1'b0, pr = 1'b0, plast = 1'b0, pdone = 1'b0;
  logic [W-1:0] pdat = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      ost = 0; pv = 1'b0; pdone = 1'b0;
    end else begin
      chk("read_while_empty", {31'd0, fifo_read & fifo_empty}, 0);
      if (pv && !pr) begin
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data", {24'd0, out_data}, {24'd0, pdat});
        chk("stall_last", {31'd0, out_last}, {31'd0, plast});
      end
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      ost = ost + int'(fifo_read) - int'(out_valid && out_ready);
      chk("outstanding_le2", {31'd0, ost <= 2}, 1);
      if (fifo_read) reads_total++;
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", {31'd0, pdone}, 0);
      end
      pv = out_valid; pr = out_ready; pdat = out_data; plast = out_last; pdone = done;
    end
  end

  int base, g0, d0, r0;

  task automatic push_word(input logic [W-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the start edge.
  task automatic start_burst(input int len);
    base = rd_ptr; g0 = got_q.size(); d0 = done_cnt; r0 = reads_total;
    start = 1'b1; burst_len = len[LW-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int mode, input int pend);
    int p = pend;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) break;
      case (mode)
        1:       out_ready = (i % 3 == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (p > 0 && $urandom_range(0, 2) == 0) begin
        push_word(W'($urandom));
        p--;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic check_burst(input string tag, input int len);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_busy_after"}, {31'd0, busy}, 0);
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_word_count"}, got_q.size() - g0, len);
    chk({tag, "_read_count"}, reads_total - r0, len);
    for (int k = 0; k < len && g0 + k < got_q.size(); k++) begin
      chk({tag, "_data"}, {23'd0, got_q[g0+k][W-1:0]}, {24'd0, mem[base+k]});
      chk({tag, "_last"}, {31'd0, got_q[g0+k][W]}, {31'd0, k == len - 1});
    end
  endtask

  initial begin
    int n, d, pre, len, mode;
    rstn = 1'b0;
    #1;
    chk("rst_fifo_read", {31'd0, fifo_read}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_out_last", {31'd0, out_last}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // basic 4-word burst with cycle-accurate timing
    for (int i = 0; i < 4; i++) push_word(W'(8'h11 + i));
    out_ready = 1'b1;
    start_burst(4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("t1_fifo_read", {31'd0, fifo_read}, {31'd0, c >= 1 && c <= 4});
      chk("t1_out_valid", {31'd0, out_valid}, {31'd0, c >= 3 && c <= 6});
      if (c >= 3 && c <= 6) begin
        chk("t1_out_data", {24'd0, out_data}, 32'h11 + c - 3);
        chk("t1_out_last", {31'd0, out_last}, {31'd0, c == 6});
      end
      chk("t1_done", {31'd0, done}, {31'd0, c == 7});
      chk("t1_busy", {31'd0, busy}, {31'd0, c <= 6});
    end
    @(posedge clk); #1;
    check_burst("t1", 4);

    // fifo starts empty, words trickle in
    start_burst(3);
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) push_word(8'hA0);
      if (c == 9) begin push_word(8'hA1); push_word(8'hA2); end
      @(posedge clk); #1;
    end
    wait_done("t3", 0, 0);
    check_burst("t3", 3);

    // back-pressure pattern 1,0,0,1,... on an 8-word fifo, burst of 6
    for (int i = 0; i < 8; i++) push_word(W'(8'h30 + i));
    start_burst(6);
    wait_done("t2", 1, 0);
    check_burst("t2", 6);
    chk("t2_fifo_left", wr_ptr - rd_ptr, 2);

    // empty burst
    n = rd_ptr;
    start_burst(0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t4_done", {31'd0, done}, {31'd0, c == 1});
      chk("t4_busy", {31'd0, busy}, 0);
      chk("t4_fifo_read", {31'd0, fifo_read}, 0);
    end
    @(posedge clk); #1;
    chk("t4_no_pops", rd_ptr - n, 0);
    chk("t4_done_count", done_cnt - d0, 1);

    // start re-pulsed during an active burst
    for (int i = 0; i < 3; i++) push_word(W'(8'h50 + i));
    out_ready = 1'b1;
    start_burst(3);
    start = 1'b1; burst_len = LW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 0, 0);
    check_burst("t5", 3);

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) push_word(W'(8'h60 + i));
    out_ready = 1'b1;
    start_burst(4);
    for (int i = 0; i < 50 && (got_q.size() - g0) < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("t6_two_delivered", got_q.size() - g0, 2);
    #2 rstn = 1'b0;
    #1;
    chk("t6_fifo_read", {31'd0, fifo_read}, 0);
    chk("t6_out_valid", {31'd0, out_valid}, 0);
    chk("t6_out_data", {24'd0, out_data}, 0);
    chk("t6_out_last", {31'd0, out_last}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_done", {31'd0, done}, 0);
    d = done_cnt;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt - d, 0);
    for (int k = 0; k < 2; k++)
      chk("t6_pre_reset_data", {23'd0, got_q[g0+k]}, {24'd0, mem[base+k]});
    for (int i = 0; i < 3; i++) push_word(W'(8'h70 + i));
    start_burst(3);
    wait_done("t6b", 0, 0);
    check_burst("t6b", 3);

    // random bursts, random back-pressure, fifo filled during the burst
    for (int t = 0; t < 12; t++) begin
      len  = $urandom_range(0, MB);
      pre  = $urandom_range(0, len);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) push_word(W'($urandom));
      start_burst(len);
      wait_done("rnd", mode, len - pre);
      check_burst("rnd", len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side engine for the project fifo; drains a programmed number of words and presents them on a valid/ready stream.
- Sits between the fifo read port (fifo_read, fifo_empty, fifo_data_out) and a downstream consumer.
- Absorbs the fifo's 1-cycle read latency and consumer back-pressure in a 2-entry output buffer.
- Reports burst start/finish via busy and done.

Parameters:
- fifo_width, 8, data width; matches the fifo's fifo_width.
- max_burst, 16, largest burst length accepted; LW = $clog2(max_burst+1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  burst request, sampled in IDLE only.
- burst_len  input  LW  words to read; sampled with start; 0 = empty burst.
- busy  output  1  high in READ and DRAIN.
- done  output  1  single-cycle pulse when a burst completes.
- fifo_read  output  1  pop request to fifo.
- fifo_empty  input  1  fifo empty flag.
- fifo_data_out  input  fifo_width  fifo read data, valid the cycle after a pop.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts when high with out_valid.
- out_data  output  fifo_width  head of output buffer.
- out_last  output  1  marks the final word of the burst.

Behaviour:
- Reset (async, rstn=0):
  - fifo_read=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - Buffer occupancy=0, inflight=0, both remaining counters=0, state=IDLE.
- Fifo timing contract: fifo_read high in cycle c pops a word, and fifo_data_out holds it during c+1. The reader captures it into the buffer at the end of c+1.
- Definitions:
  - pop = out_valid & out_ready.
  - inflight = fifo_read registered from the previous cycle.
  - occ = buffer entries (0..2).
- fifo_read is combinational: state==READ & !fifo_empty & issue_rem!=0 & (occ + inflight - pop) < 2.
  - It is never high while fifo_empty=1 or outside READ.
- FSM:
  - IDLE: on start, issue_rem and out_rem load burst_len. burst_len!=0 goes to READ; burst_len==0 goes to DONE.
  - READ: each fifo_read decrements issue_rem. When the decrement reaches 0, go to DRAIN.
  - DRAIN: each pop decrements out_rem. When the pop with out_rem==1 occurs, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - out_rem also decrements on pops during READ.
- start in any state other than IDLE is ignored; burst_len is only sampled in IDLE.
- Latency: with start sampled at edge E0, fifo non-empty and out_ready=1:
  - fifo_read is high in cycle 1.
  - out_valid first rises in cycle 3.
  - Thereafter 1 word/cycle sustained.
- Buffer is 2-entry FIFO order: out_data/out_last come from the head entry.
  - While out_valid=1 and out_ready=0, out_valid, out_data and out_last stay stable.
  - A simultaneous capture and pop is legal; occupancy is unchanged.
- out_last=1 only when the head word is the final word of the burst (out_rem==1).
- Fifo going empty mid-burst stalls issue with no error; reading resumes when fifo_empty deasserts.
- Buffer overflow cannot occur by construction. Verification asserts occ<=2.
- Reset mid-burst aborts the burst: buffered and in-flight words are discarded, and done is not pulsed.
- No combinational path from out_ready to out_valid. out_ready does feed fifo_read, via pop.

Test Plan:
- Write 0x11..0x14 into fifo. Pulse start with burst_len=4, out_ready=1 -> fifo_read high cycles 1-4; out_data 0x11,0x12,0x13,0x14 in cycles 3-6; out_last with 0x14; done cycle 7; busy low afterwards.
- Fifo holds 8 words, burst_len=6, out_ready toggled 1,0,0,1,... -> out_data never changes while stalled; at most 2 reads outstanding; exactly 6 pops; fifo retains 2 words.
- Fifo starts empty, burst_len=3. Write 0xA0 at cycle 5, 0xA1 and 0xA2 at cycle 9 -> no fifo_read while empty; words 0xA0,0xA1,0xA2 delivered in order; single done pulse.
- burst_len=0 with start -> done pulses the cycle after start, busy never rises, fifo_read never asserts.
- start re-pulsed with burst_len=5 during an active burst of 3 -> ignored; exactly 3 words plus 1 done, no extra reads.
- rstn driven low after 2 of 4 words delivered -> all outputs 0 immediately (async); no done; a new burst after reset works normally.
